// File: rtl/imem_loader.sv
// Writable instruction memory fed by a framed UART byte stream. Assembles little-endian words,
// validates a checksum and holds the CPU on NOPs until a frame has loaded cleanly.
module imem_loader #(
  parameter int unsigned ADDR_W        = 10,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] Address,
  output logic [31:0]       Data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              err
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam logic [7:0]  SyncByte = 8'hA5;
  localparam logic [31:0] NopInsn  = 32'h0000_0013;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [2:0][7:0]   word_lo_q, word_lo_d;
  logic [7:0]        csum_q, csum_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0]       mem [Depth];
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              accept;
  logic [15:0]       len_word;
  logic              len_bad;

  assign rx_ready = ~rst;
  assign accept   = rx_valid & ~rst;

  assign len_word = {rx_data, len_lo_q};
  assign len_bad  = (len_word == 16'd0) || (32'(len_word) > Depth);

  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    last_d    = last_q;
    waddr_d   = waddr_q;
    bidx_d    = bidx_q;
    word_lo_d = word_lo_q;
    csum_d    = csum_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_wdata = {rx_data, word_lo_q[2], word_lo_q[1], word_lo_q[0]};

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == SyncByte) begin
            state_d = StLenLo;
            hold_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            waddr_d = '0;
            bidx_d  = '0;
            csum_d  = '0;
          end
        end
        StLenLo: begin
          len_lo_d = rx_data;
          state_d  = StLenHi;
        end
        StLenHi: begin
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            // Length is at most Depth here, so N-1 always fits the address width.
            last_d  = ADDR_W'(len_word - 16'd1);
            state_d = StData;
          end
        end
        StData: begin
          csum_d = csum_q + rx_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            mem_we = 1'b1;
            if (waddr_q == last_q) begin
              state_d = StCsum;
            end else begin
              waddr_d = waddr_q + 1'b1;
            end
          end else begin
            word_lo_d[bidx_q] = rx_data;
          end
        end
        StCsum: begin
          if (rx_data == csum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      len_lo_q  <= '0;
      last_q    <= '0;
      waddr_q   <= '0;
      bidx_q    <= '0;
      word_lo_q <= '0;
      csum_q    <= '0;
      hold_q    <= HOLD_AT_RESET;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      last_q    <= last_d;
      waddr_q   <= waddr_d;
      bidx_q    <= bidx_d;
      word_lo_q <= word_lo_d;
      csum_q    <= csum_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr_q] <= mem_wdata;
    end
  end

  assign Data      = hold_q ? NopInsn : mem[Address];
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: literal frames, a table of frame descriptors and randomized payloads
// checked against a frame-level model of memory and status flags.
module tb_imem_loader;

  localparam int unsigned AW    = 10;
  localparam int unsigned Depth = 1024;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready, rx_ready_h0;
  logic [AW-1:0] addr;
  logic [31:0]   data, data_h0;
  logic          hold, done, err;
  logic          hold_h0, done_h0, err_h0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW), .HOLD_AT_RESET(1'b1)) u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .Address(addr), .Data(data), .cpu_hold(hold), .load_done(done), .err(err)
  );

  imem_loader #(.ADDR_W(AW), .HOLD_AT_RESET(1'b0)) u_dut_h0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready_h0),
    .Address(addr), .Data(data_h0), .cpu_hold(hold_h0), .load_done(done_h0), .err(err_h0)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_mem [Depth];
  bit          model_known [Depth];
  bit          m_hold, m_done, m_err;

  typedef struct {
    int unsigned n;
    bit          len_over;
    logic [15:0] len_field;
    logic [7:0]  csum_xor;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
    int unsigned g;
    g = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
    repeat (g) begin
      rx_valid = 1'b0;
      rx_data  = 8'hA5;  // idle cycles carry a sync byte that must be ignored
      @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'hA5;
  endtask

  // Frame-level model: sync clears flags, a bad length errors, payload fills memory from 0,
  // and the checksum byte decides done versus error.
  task automatic send_frame(input logic [31:0] words [$], input logic [15:0] len_field,
                            input logic [7:0] csum_xor, input int unsigned gap);
    logic [7:0] sum;
    sum = 8'd0;
    send_byte(8'hA5, gap);
    m_hold = 1'b1;
    m_done = 1'b0;
    m_err  = 1'b0;
    send_byte(len_field[7:0], gap);
    send_byte(len_field[15:8], gap);
    if (len_field == 16'd0 || len_field > 16'(Depth)) begin
      m_err = 1'b1;
      return;
    end
    for (int i = 0; i < words.size(); i++) begin
      for (int k = 0; k < 4; k++) send_byte(words[i][8*k +: 8], gap);
      sum = sum + words[i][7:0] + words[i][15:8] + words[i][23:16] + words[i][31:24];
      model_mem[i]   = words[i];
      model_known[i] = 1'b1;
    end
    send_byte(sum ^ csum_xor, gap);
    if (csum_xor == 8'd0) begin
      m_done = 1'b1;
      m_hold = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic check_flags(input string name);
    check({name, "_hold"}, 32'(hold), 32'(m_hold));
    check({name, "_done"}, 32'(done), 32'(m_done));
    check({name, "_err"}, 32'(err), 32'(m_err));
  endtask

  task automatic scan(input string name, input int unsigned lo, input int unsigned hi);
    int unsigned errs;
    logic [31:0] exp;
    errs = 0;
    for (int unsigned a = lo; a <= hi; a++) begin
      if (model_known[a]) begin
        addr = AW'(a);
        #1;
        exp = m_hold ? Nop : model_mem[a];
        if (data !== exp) errs++;
      end
    end
    check({name, "_mismatches"}, errs, 32'd0);
  endtask

  logic [7:0]  spec_bytes [12];
  vec_t        vecs [8];
  logic [31:0] wq [$];
  logic [31:0] w_old [4];

  initial begin
    spec_bytes = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    vecs[0] = '{4, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{2, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{3, 1'b0, 16'h0000, 8'h01, 1'b0, 1'b1};
    vecs[3] = '{1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{0, 1'b1, 16'h0401, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{5, 1'b0, 16'h0000, 8'h80, 1'b0, 1'b1};
    vecs[7] = '{7, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0};
    for (int i = 0; i < Depth; i++) model_known[i] = 1'b0;

    // Reset state
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; addr = AW'(5);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_hold", 32'(hold), 32'd1);
    check("rst_hold_h0", 32'(hold_h0), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_data_nop", data, Nop);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(rx_ready), 32'd1);
    m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;

    // Literal frame; hold must stay up until the checksum byte is accepted
    for (int i = 0; i < 11; i++) send_byte(spec_bytes[i], 0);
    addr = AW'(1);
    #1;
    check("pre_csum_hold", 32'(hold), 32'd1);
    check("pre_csum_data_nop", data, Nop);
    send_byte(spec_bytes[11], 0);
    check("spec_done", 32'(done), 32'd1);
    check("spec_err", 32'(err), 32'd0);
    check("spec_hold", 32'(hold), 32'd0);
    check("spec_data1", data, 32'h0010_0093);
    addr = AW'(0);
    #1;
    check("spec_data0", data, 32'h0000_0013);
    model_mem[0] = 32'h0000_0013; model_mem[1] = 32'h0010_0093;
    model_known[0] = 1'b1; model_known[1] = 1'b1;
    m_hold = 1'b0; m_done = 1'b1; m_err = 1'b0;

    // Same frame with a wrong checksum
    for (int i = 0; i < 11; i++) send_byte(spec_bytes[i], 2);
    send_byte(8'hB7, 2);
    check("badcs_err", 32'(err), 32'd1);
    check("badcs_done", 32'(done), 32'd0);
    check("badcs_hold", 32'(hold), 32'd1);
    addr = AW'(1);
    #1;
    check("badcs_nop1", data, Nop);
    addr = AW'(700);
    #1;
    check("badcs_nop700", data, Nop);
    m_hold = 1'b1; m_done = 1'b0; m_err = 1'b1;

    // Stray bytes ahead of the sync are discarded
    send_byte(8'h00, 1); send_byte(8'hFF, 1); send_byte(8'h13, 1);
    wq = {32'h0000_0013, 32'h0010_0093};
    send_frame(wq, 16'd2, 8'h00, 1);
    check_flags("stray");
    addr = AW'(1);
    #1;
    check("stray_data1", data, 32'h0010_0093);

    // Table of frames with random payloads
    for (int v = 0; v < 8; v++) begin
      logic [15:0] len;
      wq = {};
      for (int i = 0; i < vecs[v].n; i++) wq.push_back($urandom);
      len = vecs[v].len_over ? vecs[v].len_field : 16'(vecs[v].n);
      send_frame(wq, len, vecs[v].csum_xor, 3);
      check($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
      check($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d_hold", v), 32'(hold), 32'(!vecs[v].exp_done));
      check_flags($sformatf("vec%0d_model", v));
      scan($sformatf("vec%0d_mem", v), 0, 15);
      if (v == 4) send_byte(8'hDE, 0);  // junk after a length error is ignored in idle
    end

    // Full-depth frame, data = address, with and without gaps between bytes
    for (int pass = 0; pass < 2; pass++) begin
      wq = {};
      for (int i = 0; i < Depth; i++) wq.push_back(32'(i));
      send_frame(wq, 16'(Depth), 8'h00, pass * 4);
      check_flags($sformatf("full%0d", pass));
      scan($sformatf("full%0d_mem", pass), 0, Depth - 1);
      addr = AW'(Depth - 1);
      #1;
      check($sformatf("full%0d_last", pass), data, 32'(Depth - 1));
    end

    // Reset mid-frame after six payload bytes
    wq = {};
    for (int i = 0; i < 4; i++) begin
      w_old[i] = $urandom;
      wq.push_back(w_old[i]);
    end
    send_frame(wq, 16'd4, 8'h00, 0);
    check_flags("pre_mid");
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h0D, 0); send_byte(8'hF0, 0); send_byte(8'hFE, 0); send_byte(8'hCA, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ready", 32'(rx_ready), 32'd0);
    rst = 1'b0;
    model_mem[0] = 32'hCAFE_F00D;
    m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;
    check_flags("mid");
    check("mid_hold_h0", 32'(hold_h0), 32'd0);
    check("mid_done_h0", 32'(done_h0), 32'd0);
    check("mid_err_h0", 32'(err_h0), 32'd0);
    addr = AW'(0);
    #1;
    check("mid_h0_word0", data_h0, 32'hCAFE_F00D);
    check("mid_nop", data, Nop);
    addr = AW'(1);
    #1;
    check("mid_h0_word1_kept", data_h0, w_old[1]);
    addr = AW'(2);
    #1;
    check("mid_h0_word2_kept", data_h0, w_old[2]);
    wq = {32'h1234_5678};
    send_frame(wq, 16'd1, 8'h00, 2);
    check_flags("post_mid");
    addr = AW'(0);
    #1;
    check("post_mid_word0", data, 32'h1234_5678);
    addr = AW'(1);
    #1;
    check("post_mid_word1", data, w_old[1]);
    scan("post_mid_mem", 0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
